// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : Transmit-side UART framer. A byte offered with a one-cycle
//               valid strobe while idle is latched and sent as one frame:
//               start bit (0), DATA_WIDTH data bits LSB-first, an optional
//               parity bit, then one stop bit (1). One clock is one bit period.
//
// Ports       : CLK_UART_TX        in   TX bit clock, rising edge
//               RST_UART_TX        in   asynchronous active-low reset
//               P_DATA_UART_TX     in   payload, sampled on an accepted strobe
//               DATA_VALID_UART_TX in   single-cycle request strobe
//               PAR_EN_UART_TX     in   1 = insert parity bit
//               PAR_TYP_UART_TX    in   0 = even parity, 1 = odd parity
//               TX_OUT_UART_TX     out  serial line, idles high (registered)
//               BUSY_UART_TX       out  high from start bit through stop bit
//                                       (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK_UART_TX,
    input  logic                  RST_UART_TX,
    input  logic [DATA_WIDTH-1:0] P_DATA_UART_TX,
    input  logic                  DATA_VALID_UART_TX,
    input  logic                  PAR_EN_UART_TX,
    input  logic                  PAR_TYP_UART_TX,
    output logic                  TX_OUT_UART_TX,
    output logic                  BUSY_UART_TX
);

    localparam int c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [c_IDX_W-1:0]    r_bit_idx;
    logic                  w_accept;
    logic                  w_last_bit;
    logic                  w_parity;
    logic                  w_tx_next;
    logic                  w_busy_next;

    assign w_accept   = (r_state == c_ST_IDLE) && DATA_VALID_UART_TX;
    assign w_last_bit = (r_bit_idx == c_LAST_IDX);
    // Even parity bit equals the XOR of the data; odd parity is its inverse.
    assign w_parity   = r_par_typ ? ~(^r_data) : (^r_data);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_UART_TX or negedge RST_UART_TX) begin
        if (!RST_UART_TX) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_state_next = c_ST_START;
            c_ST_START:  w_state_next = c_ST_DATA;
            c_ST_DATA: begin
                if (w_last_bit) begin
                    w_state_next = r_par_en ? c_ST_PARITY : c_ST_STOP;
                end
            end
            c_ST_PARITY: w_state_next = c_ST_STOP;
            c_ST_STOP:   w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. The line value for the current state is registered
    // one cycle later, which gives the one-cycle strobe-to-start latency
    // and keeps the pad free of decode glitches.
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
            end
            c_ST_START: begin
                w_tx_next   = 1'b0;
                w_busy_next = 1'b1;
            end
            c_ST_DATA: begin
                w_tx_next   = r_data[r_bit_idx];
                w_busy_next = 1'b1;
            end
            c_ST_PARITY: begin
                w_tx_next   = w_parity;
                w_busy_next = 1'b1;
            end
            c_ST_STOP: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b1;
            end
            default: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_UART_TX or negedge RST_UART_TX) begin
        if (!RST_UART_TX) begin
            TX_OUT_UART_TX <= 1'b1;
            BUSY_UART_TX   <= 1'b0;
        end else begin
            TX_OUT_UART_TX <= w_tx_next;
            BUSY_UART_TX   <= w_busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame capture: payload and configuration are frozen at acceptance
    // so input changes during a frame cannot corrupt it.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_UART_TX or negedge RST_UART_TX) begin
        if (!RST_UART_TX) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_accept) begin
            r_data    <= P_DATA_UART_TX;
            r_par_en  <= PAR_EN_UART_TX;
            r_par_typ <= PAR_TYP_UART_TX;
        end
    end

    // ------------------------------------------------------------------
    // Bit index: held at zero outside DATA, so it is zero on entry, and
    // cleared on the last data bit instead of wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_UART_TX or negedge RST_UART_TX) begin
        if (!RST_UART_TX) begin
            r_bit_idx <= '0;
        end else if (r_state == c_ST_DATA) begin
            r_bit_idx <= w_last_bit ? '0 : r_bit_idx + 1'b1;
        end else begin
            r_bit_idx <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame. Frames observed on the
//               line are compared with frames built by a bit-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pdata = 8'h00;
    logic       valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       tx;
    logic       busy;

    int tests = 0;
    int fails = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK_UART_TX        (clk),
        .RST_UART_TX        (rst_n),
        .P_DATA_UART_TX     (pdata),
        .DATA_VALID_UART_TX (valid),
        .PAR_EN_UART_TX     (par_en),
        .PAR_TYP_UART_TX    (par_typ),
        .TX_OUT_UART_TX     (tx),
        .BUSY_UART_TX       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: list of line bits, start first, stop last.
    function automatic void model_frame(input logic [7:0] d, input logic pen,
                                        input logic ptyp,
                                        output logic [31:0] bits, output int n);
        int ones;
        bits = '0;
        n    = 0;
        ones = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i]; n++;
            if (d[i]) ones++;
        end
        if (pen) begin
            // even: total ones even; odd: total ones odd
            bits[n] = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
            n++;
        end
        bits[n] = 1'b1; n++;
    endfunction

    task automatic strobe(input logic [7:0] d, input logic pen, input logic ptyp);
        pdata   = d;
        par_en  = pen;
        par_typ = ptyp;
        valid   = 1'b1;
        tick();
        valid   = 1'b0;
    endtask

    // Records line bits while busy; optionally raises a strobe with inj_data
    // right after sample number inject_at. Bounded to 32 samples.
    task automatic capture(input int inject_at, input logic [7:0] inj_data,
                           output logic [31:0] bits, output int n);
        bits = '0;
        n    = 0;
        tick();
        while (busy === 1'b1 && n < 32) begin
            bits[n] = tx;
            n++;
            if (n - 1 == inject_at) begin
                valid = 1'b1;
                pdata = inj_data;
            end else begin
                valid = 1'b0;
            end
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: got tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_fixed_frames();
        logic [7:0]  tdat [4] = '{8'hA5, 8'h00, 8'h07, 8'h3C};
        logic        tpen [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        ttyp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] got, exp;
        int          gn, en;
        for (int i = 0; i < 4; i++) begin
            model_frame(tdat[i], tpen[i], ttyp[i], exp, en);
            strobe(tdat[i], tpen[i], ttyp[i]);
            capture(-1, 8'h00, got, gn);
            tests++;
            if (got !== exp || gn !== en) begin
                fails++;
                $display("FAIL fixed_frame_%0d: got bits=%h busy_cycles=%0d, want bits=%h busy_cycles=%0d",
                         i, got, gn, exp, en);
            end
            tests++;
            if (tx !== 1'b1) begin
                fails++;
                $display("FAIL fixed_idle_%0d: got tx=%b, want 1", i, tx);
            end
        end
    endtask

    task automatic test_random_frames();
        logic [31:0] got, exp;
        int          gn, en;
        logic [7:0]  d;
        logic        pen, ptyp;
        for (int i = 0; i < 16; i++) begin
            d    = 8'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            model_frame(d, pen, ptyp, exp, en);
            strobe(d, pen, ptyp);
            capture(-1, 8'h00, got, gn);
            tests++;
            if (got !== exp || gn !== en) begin
                fails++;
                $display("FAIL random_frame d=%h pen=%b typ=%b: got bits=%h n=%0d, want bits=%h n=%0d",
                         d, pen, ptyp, got, gn, exp, en);
            end
        end
    endtask

    task automatic test_ignore_busy_strobe();
        logic [31:0] got, exp;
        int          gn, en, extra;
        model_frame(8'h12, 1'b1, 1'b0, exp, en);
        strobe(8'h12, 1'b1, 1'b0);
        capture(3, 8'hFF, got, gn);
        tests++;
        if (got !== exp || gn !== en) begin
            fails++;
            $display("FAIL ignore_frame: got bits=%h n=%0d, want bits=%h n=%0d", got, gn, exp, en);
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy !== 1'b0 || tx !== 1'b1) extra++;
            tick();
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL ignore_no_second: got %0d non-idle cycles, want 0", extra);
        end
    endtask

    task automatic test_latch();
        logic [31:0] got, exp;
        int          gn, en;
        model_frame(8'hC3, 1'b1, 1'b0, exp, en);
        strobe(8'hC3, 1'b1, 1'b0);
        pdata   = 8'h3C;
        par_typ = 1'b1;
        par_en  = 1'b0;
        capture(-1, 8'h3C, got, gn);
        tests++;
        if (got !== exp || gn !== en) begin
            fails++;
            $display("FAIL latch_frame: got bits=%h n=%0d, want bits=%h n=%0d", got, gn, exp, en);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] got, exp;
        int          gn, en;
        strobe(8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_busy_before: got busy=%b, want 1", busy);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_async: got tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        model_frame(8'h81, 1'b1, 1'b1, exp, en);
        strobe(8'h81, 1'b1, 1'b1);
        capture(-1, 8'h00, got, gn);
        tests++;
        if (got !== exp || gn !== en) begin
            fails++;
            $display("FAIL post_reset_frame: got bits=%h n=%0d, want bits=%h n=%0d", got, gn, exp, en);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got1, exp1, got2, exp2;
        int          gn1, en1, gn2, en2;
        logic        pen, ptyp;
        pen  = 1'($urandom);
        ptyp = 1'($urandom);
        model_frame(8'h55, pen, ptyp, exp1, en1);
        model_frame(8'hAA, pen, ptyp, exp2, en2);
        strobe(8'h55, pen, ptyp);
        // second strobe presented for the edge where BUSY falls
        capture(en1 - 1, 8'hAA, got1, gn1);
        tests++;
        if (got1 !== exp1 || gn1 !== en1) begin
            fails++;
            $display("FAIL b2b_first: got bits=%h n=%0d, want bits=%h n=%0d", got1, gn1, exp1, en1);
        end
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_bit: got tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end
        capture(-1, 8'h00, got2, gn2);
        tests++;
        if (got2 !== exp2 || gn2 !== en2) begin
            fails++;
            $display("FAIL b2b_second: got bits=%h n=%0d, want bits=%h n=%0d", got2, gn2, exp2, en2);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_frames();
        test_random_frames();
        test_ignore_busy_strobe();
        test_latch();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
# uart_tx_frame

Transmit-side UART framer: accepts a parallel byte with a one-cycle valid strobe, then serialises a complete frame (start bit, data LSB-first, optional parity, stop bit) on a single line, one bit per clock. It is the TX counterpart of the RX parity-check/deserialise path. It runs on the TX bit clock, so one clock equals one bit period, and its line output connects directly to the pad.

## Interface
Parameters:
- DATA_WIDTH, 8, payload bits per frame; counter width is clog2(DATA_WIDTH).

Ports:
- CLK_UART_TX  in  1  TX bit clock; all state updates on rising edge.
- RST_UART_TX  in  1  reset, asynchronous, active-low.
- P_DATA_UART_TX  in  DATA_WIDTH  payload to send; sampled only on an accepted strobe.
- DATA_VALID_UART_TX  in  1  single-cycle request strobe.
- PAR_EN_UART_TX  in  1  1 = insert parity bit.
- PAR_TYP_UART_TX  in  1  0 = even, 1 = odd.
- TX_OUT_UART_TX  out  1  serial line; idles high. Registered.
- BUSY_UART_TX  out  1  high from the first start-bit cycle through the last stop-bit cycle. Registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - A strobe is accepted only when DATA_VALID_UART_TX=1 at a rising edge with the FSM in IDLE.
  - On acceptance, P_DATA, PAR_EN and PAR_TYP are latched into internal registers. Later input changes do not affect the frame in flight.
  - A strobe while BUSY_UART_TX=1 is ignored. It is not queued.
- Parity is computed from the latched data: even = XOR-reduce(data); odd = XNOR-reduce(data).
- Transitions:
  - IDLE→START on acceptance.
  - START→DATA after 1 cycle.
  - DATA stays DATA_WIDTH cycles, with bit index 0..DATA_WIDTH-1. On the last bit it goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY→STOP after 1 cycle.
  - STOP→IDLE after 1 cycle.
- Line value per state: IDLE = 1, START = 0, DATA = data[index], PARITY = parity bit, STOP = 1.
- BUSY_UART_TX = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- The bit-index counter:
  - resets to 0 on entry to DATA;
  - increments each DATA cycle;
  - never wraps inside a frame;
  - is cleared on exit from DATA.
- Reset (asynchronous, any time including mid-frame): FSM→IDLE, TX_OUT_UART_TX=1, BUSY_UART_TX=0, counter=0, latched data/config=0. A partial frame is simply truncated; no resumption.
- Reset values of outputs: TX_OUT_UART_TX=1, BUSY_UART_TX=0.

## Timing
- Strobe accepted at edge k:
  - edge k+1: TX_OUT=0 (start bit), BUSY=1;
  - edges k+2 … k+1+DATA_WIDTH: data bits 0..DATA_WIDTH-1;
  - edge k+2+DATA_WIDTH: parity bit if enabled, otherwise stop bit.
- Stop bit lasts exactly 1 cycle.
- BUSY falls, and TX_OUT stays 1, at the edge after the stop cycle:
  - k+12 with parity, k+11 without (DATA_WIDTH=8).
- Earliest next acceptance is the first edge with the FSM in IDLE, i.e. the edge where BUSY falls.
  - Frame-to-frame period is therefore 12 cycles with parity and 11 without (DATA_WIDTH=8), each including one idle-high bit.
- Latency from strobe to first line transition: 1 cycle.
- Strobe coincident with reset deassertion: accepted only if reset was released before that edge; no glitch on TX_OUT in any case.

## Test plan
- Send 0xA5 with PAR_EN=1, PAR_TYP=0 → line sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop); BUSY high exactly 11 cycles.
- Send 0x00 with PAR_EN=1, PAR_TYP=1 → 0, eight 0s, 1(parity), 1(stop); 0x07 even → parity bit 1.
- Send 0x3C with PAR_EN=0 → 0,0,0,1,1,1,1,0,0,1(stop); BUSY high 10 cycles; no parity slot.
- Pulse DATA_VALID with 0xFF during the DATA state of a 0x12 frame → 0x12 frame is unaltered and no second frame follows.
- Change P_DATA/PAR_TYP on the cycle after acceptance → frame uses the latched values.
- Assert RST_UART_TX mid-DATA → TX_OUT=1 and BUSY=0 immediately (asynchronous). After release, a fresh 0x81 strobe yields a complete correct frame with latency 1.
- Back-to-back: strobe 0x55 then strobe 0xAA on the edge where BUSY falls → second start bit follows the idle bit with no gap beyond it; both frames decode correctly.
